// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   WORD_W     : data word width (32 bits).
//   state_e    : responder control states, IDLE (accepting) and WAIT
//                (counting down to a scheduled response).
//   resp_t     : response payload, load data plus misalignment flag.
//   cnt_width(): bits needed for a latency countdown that starts at
//                LATENCY-1 (never less than one bit).
package dmem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              err;
  } resp_t;

  function automatic int cnt_width(input int latency);
    return (latency < 2) ? 1 : $clog2(latency);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word RAM built from four byte lanes.
//   clk   : clock, rising edge.
//   en    : access strobe for this cycle.
//   we    : 1 = write the enabled byte lanes, 0 = read.
//   be    : per-byte write enable (bit i covers wdata[8i+7:8i]).
//   addr  : word index.
//   wdata : write data.
//   rdata : read data, registered on the edge of a read access and held
//           until the next read; writes never disturb it.
// The memory contents are not reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata
);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (en) begin
        if (we) begin
          if (be[gi]) begin
            mem[addr] <= wdata[gi*8 +: 8];
          end
        end else begin
          rd_q <= mem[addr];
        end
      end
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory model for a pipeline memory stage.
// Accepts one load/store per handshake and returns a one-cycle response
// pulse LATENCY cycles after acceptance (the pulse is the cycle that ends
// on edge N+LATENCY when the request was taken on edge N).
//   clk        : clock, rising edge.
//   rst_n      : asynchronous active-low reset.
//   req_valid  : request present.
//   req_ready  : responder idle and able to accept (from state only).
//   req_we     : 1 = store, 0 = load.
//   req_addr   : byte address; word index is req_addr[AW+1:2].
//   req_wdata  : store data.
//   req_be     : byte enables for stores (only with DMEM_BYTE_EN_EN).
//   resp_valid : one-cycle response pulse.
//   resp_rdata : load data, zero for stores and misaligned accesses, held
//                until the next response.
//   resp_err   : misaligned access, qualified by resp_valid.
// Build option: define DMEM_BYTE_EN_EN to add req_be; otherwise every store
// writes the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
`ifdef DMEM_BYTE_EN_EN
  input  logic [3:0]        req_be,
`endif
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_err_q, pend_err_d;
  logic          pend_zero_q, pend_zero_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic          resp_zero_q, resp_zero_d;

  logic              accept;
  logic              misaligned;
  logic              last_wait;
  logic [3:0]        wr_be;
  logic [WORD_W-1:0] ram_rdata;
  logic [WORD_W-1:0] data_src;
  resp_t             resp_out;

  // Address bits above the word index are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:AW+2];

`ifdef DMEM_BYTE_EN_EN
  assign wr_be = req_be;
`else
  assign wr_be = 4'hF;
`endif

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_valid && req_ready;
  assign misaligned = (req_addr[1:0] != 2'b00);
  assign last_wait  = (state_q == WAIT) && (cnt_q == CNT_ONE);

  // The RAM read register doubles as the pending load data: it only
  // updates on an accepted aligned load, and no request is accepted while
  // a response is still pending.
  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (accept && !misaligned),
    .we    (req_we),
    .be    (wr_be),
    .addr  (req_addr[AW+1:2]),
    .wdata (req_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_err_d   = pend_err_q;
    pend_zero_d  = pend_zero_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_zero_d  = resp_zero_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pend_err_d  = misaligned;
          pend_zero_d = misaligned || req_we;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            // Single-cycle latency: the response is issued on the
            // acceptance edge itself.
            resp_valid_d = 1'b1;
            resp_err_d   = misaligned;
            resp_zero_d  = misaligned || req_we;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = pend_err_q;
          resp_zero_d  = pend_zero_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_err_q   <= 1'b0;
      pend_zero_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_zero_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_err_q   <= pend_err_d;
      pend_zero_q  <= pend_zero_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_zero_q  <= resp_zero_d;
    end
  end

  // With LATENCY==1 the RAM read register changes only on the same edge
  // that issues a response, so it can drive the output directly. With a
  // longer latency the next load lands in the RAM register before its
  // response is due, so the previous data is latched at response time.
  if (LATENCY == 1) begin : g_direct
    assign data_src = ram_rdata;
  end else begin : g_hold
    logic [WORD_W-1:0] hold_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
      end else if (last_wait) begin
        hold_q <= ram_rdata;
      end
    end

    assign data_src = hold_q;
  end

  assign resp_out.err   = resp_err_q;
  assign resp_out.rdata = resp_zero_q ? '0 : data_src;

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_out.rdata;
  assign resp_err   = resp_out.err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed bench for dmem_responder. Three instances
// (LATENCY 1, 3 and 4, DEPTH 1024) share clock and reset; each is driven
// by hand-written request sequences with hand-computed responses.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [3:0]  req_be     [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        resp_err   [3];
  logic [31:0] resp_rdata [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dmem_responder #(
      .DEPTH   (1024),
      .LATENCY ((gi == 0) ? 1 : ((gi == 1) ? 3 : 4))
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid[gi]),
      .req_ready  (req_ready[gi]),
      .req_we     (req_we[gi]),
      .req_addr   (req_addr[gi]),
      .req_wdata  (req_wdata[gi]),
`ifdef DMEM_BYTE_EN_EN
      .req_be     (req_be[gi]),
`endif
      .resp_valid (resp_valid[gi]),
      .resp_rdata (resp_rdata[gi]),
      .resp_err   (resp_err[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = a;
    req_wdata[k] = d;
    req_be[k]    = be;
  endtask

  task automatic idle(input int k);
    req_valid[k] = 1'b0;
  endtask

  // One complete request/response, with bounded wait for the response.
  task automatic xact(input int k, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      input logic exp_err, input logic [31:0] exp_rd,
                      input int exp_lat);
    int cyc;
    drive(k, we, a, d, be);
    check("ready_before", 32'(req_ready[k]), 32'd1);
    tick();
    idle(k);
    cyc = 1;
    while (resp_valid[k] !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    $display("xact dut%0d %s addr=%h wdata=%h be=%h -> valid=%b err=%b rdata=%h lat=%0d",
             k, we ? "st" : "ld", a, d, be, resp_valid[k], resp_err[k], resp_rdata[k], cyc);
    check("resp_valid", 32'(resp_valid[k]), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("resp_err", 32'(resp_err[k]), 32'(exp_err));
    check("resp_rdata", resp_rdata[k], exp_rd);
    tick();
    check("pulse_end", 32'(resp_valid[k]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      req_we[k]    = 1'b0;
      req_addr[k]  = 32'h0;
      req_wdata[k] = 32'h0;
      req_be[k]    = 4'hF;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      check("rst_ready", 32'(req_ready[k]), 32'd1);
      check("rst_valid", 32'(resp_valid[k]), 32'd0);
      check("rst_rdata", resp_rdata[k], 32'h0);
      check("rst_err", 32'(resp_err[k]), 32'd0);
    end
    rst_n = 1'b1;
    tick();

    // LATENCY=1: back-to-back store then load.
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    check("b2b_ready0", 32'(req_ready[0]), 32'd1);
    tick();
    $display("b2b dut0 st 0x10 -> valid=%b err=%b rdata=%h", resp_valid[0], resp_err[0], resp_rdata[0]);
    check("b2b_st_valid", 32'(resp_valid[0]), 32'd1);
    check("b2b_st_err", 32'(resp_err[0]), 32'd0);
    check("b2b_st_rdata", resp_rdata[0], 32'h0);
    drive(0, 1'b0, 32'h10, 32'h0, 4'hF);
    check("b2b_ready1", 32'(req_ready[0]), 32'd1);
    tick();
    $display("b2b dut0 ld 0x10 -> valid=%b err=%b rdata=%h", resp_valid[0], resp_err[0], resp_rdata[0]);
    check("b2b_ld_valid", 32'(resp_valid[0]), 32'd1);
    check("b2b_ld_rdata", resp_rdata[0], 32'hDEADBEEF);
    check("b2b_ready2", 32'(req_ready[0]), 32'd1);
    idle(0);
    tick();
    check("b2b_end_valid", 32'(resp_valid[0]), 32'd0);
    check("b2b_hold_rdata", resp_rdata[0], 32'hDEADBEEF);

    // Misaligned accesses leave the RAM untouched.
    xact(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 1);
    xact(0, 1'b0, 32'h13, 32'h0,        4'hF, 1'b1, 32'h0, 1);
    xact(0, 1'b1, 32'h22, 32'h12345678, 4'hF, 1'b1, 32'h0, 1);
    xact(0, 1'b0, 32'h20, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D, 1);

    // Address wraps modulo DEPTH words: 0x1004 aliases 0x4.
    xact(0, 1'b1, 32'h0000_1004, 32'h1, 4'hF, 1'b0, 32'h0, 1);
    xact(0, 1'b0, 32'h4,         32'h0, 4'hF, 1'b0, 32'h1, 1);

`ifdef DMEM_BYTE_EN_EN
    xact(0, 1'b1, 32'h30, 32'h11223344, 4'hF,    1'b0, 32'h0, 1);
    xact(0, 1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, 1'b0, 32'h0, 1);
    xact(0, 1'b0, 32'h30, 32'h0,        4'h0,    1'b0, 32'h11BB33DD, 1);
    xact(0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0,    1'b0, 32'h0, 1);
    xact(0, 1'b0, 32'h30, 32'h0,        4'hF,    1'b0, 32'h11BB33DD, 1);
`else
    // Without byte enables every store writes the whole word.
    xact(0, 1'b1, 32'h30, 32'h11223344, 4'h0, 1'b0, 32'h0, 1);
    xact(0, 1'b0, 32'h30, 32'h0,        4'h0, 1'b0, 32'h11223344, 1);
`endif

    // LATENCY=3: stall window and overlapped acceptance.
    xact(1, 1'b1, 32'h10, 32'h00000A0A, 4'hF, 1'b0, 32'h0, 3);
    xact(1, 1'b1, 32'h14, 32'h00000B0B, 4'hF, 1'b0, 32'h0, 3);
    drive(1, 1'b0, 32'h10, 32'h0, 4'hF);
    check("l3_ready_n", 32'(req_ready[1]), 32'd1);
    tick();
    check("l3_ready_n1", 32'(req_ready[1]), 32'd0);
    check("l3_valid_n1", 32'(resp_valid[1]), 32'd0);
    tick();
    check("l3_ready_n2", 32'(req_ready[1]), 32'd0);
    check("l3_valid_n2", 32'(resp_valid[1]), 32'd0);
    tick();
    $display("l3 dut1 ld 0x10 -> valid=%b ready=%b rdata=%h", resp_valid[1], req_ready[1], resp_rdata[1]);
    check("l3_valid_n3", 32'(resp_valid[1]), 32'd1);
    check("l3_ready_n3", 32'(req_ready[1]), 32'd1);
    check("l3_rdata_a", resp_rdata[1], 32'h00000A0A);
    check("l3_err_a", 32'(resp_err[1]), 32'd0);
    drive(1, 1'b0, 32'h14, 32'h0, 4'hF);
    tick();
    idle(1);
    check("l3_valid_n4", 32'(resp_valid[1]), 32'd0);
    check("l3_ready_n4", 32'(req_ready[1]), 32'd0);
    check("l3_hold", resp_rdata[1], 32'h00000A0A);
    tick();
    check("l3_valid_n5", 32'(resp_valid[1]), 32'd0);
    tick();
    $display("l3 dut1 ld 0x14 -> valid=%b ready=%b rdata=%h", resp_valid[1], req_ready[1], resp_rdata[1]);
    check("l3_valid_n6", 32'(resp_valid[1]), 32'd1);
    check("l3_rdata_b", resp_rdata[1], 32'h00000B0B);
    tick();
    check("l3_end", 32'(resp_valid[1]), 32'd0);

    // LATENCY=4: reset while a store response is pending.
    drive(2, 1'b1, 32'h8, 32'h55, 4'hF);
    tick();
    idle(2);
    tick();
    rst_n = 1'b0;
    #1;
    $display("rst dut2 mid-op -> valid=%b ready=%b err=%b rdata=%h", resp_valid[2], req_ready[2], resp_err[2], resp_rdata[2]);
    check("mid_rst_ready", 32'(req_ready[2]), 32'd1);
    check("mid_rst_valid", 32'(resp_valid[2]), 32'd0);
    check("mid_rst_rdata", resp_rdata[2], 32'h0);
    check("mid_rst_err", 32'(resp_err[2]), 32'd0);
    tick();
    check("mid_rst_valid1", 32'(resp_valid[2]), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_quiet", 32'(resp_valid[2]), 32'd0);
    end
    xact(2, 1'b0, 32'h8, 32'h0, 4'hF, 1'b0, 32'h55, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
